// File: rtl/counter_arb_pkg.sv
// Shared types and defaults for the round-robin up/down counter arbiter.
package counter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefLenW  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PtrW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_valid
);

  int unsigned w_dist;
  int unsigned w_best_dist;
  int unsigned w_best;

  always_comb begin
    w_dist      = 0;
    w_best_dist = NREQ;
    w_best      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // Distance 0 is the slot right after the last winner.
      w_dist = (i + NREQ - 32'(i_ptr) - 1) % NREQ;
      if (i_req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = i;
      end
    end
    o_valid = (w_best_dist != NREQ);
    o_gnt   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      o_gnt[i] = o_valid && (w_best == i);
    end
  end

endmodule

// File: rtl/counter_req_arbiter.sv
// Grants shared up/down counter bursts round-robin, drives step/clear strobes, mirrors the count.
module counter_req_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LEN_W = DefLenW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic                  clr_req,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  up_down,
  output logic                  down_up,
  output logic                  ctr_reset,
  output logic [WIDTH-1:0]      shadow
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            r_state;
  logic [PtrW-1:0]   r_ptr;
  logic [PtrW-1:0]   r_idx;
  logic [LEN_W-1:0]  r_rem;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic              r_busy;
  logic              r_up;
  logic              r_dn;
  logic              r_ctr_reset;
  logic [WIDTH-1:0]  r_shadow;

  logic [NREQ-1:0]   w_gnt;
  logic              w_valid;
  logic [PtrW-1:0]   w_idx;
  logic              w_dir;
  logic [LEN_W-1:0]  w_len;

  rr_arbiter #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  always_comb begin
    w_idx = '0;
    w_dir = 1'b0;
    w_len = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_idx = PtrW'(i);
        w_dir = req_dir[i];
        w_len = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= PtrW'(NREQ - 1);
      r_idx       <= '0;
      r_rem       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_up        <= 1'b0;
      r_dn        <= 1'b0;
      r_ctr_reset <= 1'b1;
      r_shadow    <= '0;
    end else begin
      r_done      <= '0;
      r_ctr_reset <= 1'b0;
      // The counter steps at the edge ending each strobe cycle; track it here.
      if (r_up) begin
        r_shadow <= r_shadow + WIDTH'(1);
      end else if (r_dn) begin
        r_shadow <= r_shadow - WIDTH'(1);
      end

      unique case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state     <= CLR;
            r_busy      <= 1'b1;
            r_ctr_reset <= 1'b1;
            r_shadow    <= '0;
          end else if (w_valid) begin
            r_gnt  <= w_gnt;
            r_idx  <= w_idx;
            r_busy <= 1'b1;
            if (w_len != '0) begin
              r_state <= RUN;
              r_rem   <= w_len;
              r_up    <= w_dir;
              r_dn    <= ~w_dir;
            end else begin
              r_state <= DONE;
              r_done  <= w_gnt;
            end
          end
        end
        CLR: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        RUN: begin
          if (r_rem == LEN_W'(1)) begin
            r_state <= DONE;
            r_up    <= 1'b0;
            r_dn    <= 1'b0;
            r_done  <= r_gnt;
          end else begin
            r_rem <= r_rem - LEN_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_gnt   <= '0;
          r_ptr   <= r_idx;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign busy      = r_busy;
  assign up_down   = r_up;
  assign down_up   = r_dn;
  assign ctr_reset = r_ctr_reset;
  assign shadow    = r_shadow;

endmodule

// File: tb/tb_counter_req_arbiter.sv
// Bench: directed scenarios plus random traffic against a queue-of-expected-cycles model.
module tb_counter_req_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned LEN_W = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ*LEN_W-1:0] req_len;
  logic                  clr_req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  up_down;
  logic                  down_up;
  logic                  ctr_reset;
  logic [WIDTH-1:0]      shadow;

  always #5 clk = ~clk;

  counter_req_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_dir   (req_dir),
    .req_len   (req_len),
    .clr_req   (clr_req),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .up_down   (up_down),
    .down_up   (down_up),
    .ctr_reset (ctr_reset),
    .shadow    (shadow)
  );

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             busy;
    logic             up;
    logic             dn;
    logic             ctr;
    logic [WIDTH-1:0] sh;
  } rec_t;

  rec_t             exp_q[$];
  int               done_log[$];
  int               n_vec  = 0;
  int               n_miss = 0;
  int unsigned      m_ptr  = NREQ - 1;
  logic [WIDTH-1:0] m_shadow = '0;
  bit               prev_rst = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expand one arbitration decision into the per-cycle outputs it must produce.
  task automatic model_idle(input bit clr, input logic [NREQ-1:0] rq,
                            input logic [NREQ-1:0] dr, input logic [NREQ*LEN_W-1:0] ln);
    rec_t        r;
    int          j;
    int unsigned len;
    bit          d;
    int          s;
    if (clr) begin
      r = '0;
      r.busy = 1'b1;
      r.ctr  = 1'b1;
      exp_q.push_back(r);
      m_shadow = '0;
      return;
    end
    j = -1;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned c;
      c = (m_ptr + k) % NREQ;
      if (j < 0 && rq[c]) j = int'(c);
    end
    if (j < 0) return;
    len = 32'(ln[j*LEN_W +: LEN_W]);
    d   = dr[j];
    s   = int'(m_shadow);
    for (int unsigned k = 1; k <= len; k++) begin
      r = '0;
      r.gnt  = NREQ'(1) << j;
      r.busy = 1'b1;
      r.up   = d;
      r.dn   = ~d;
      r.sh   = WIDTH'(d ? s + int'(k) - 1 : s - (int'(k) - 1));
      exp_q.push_back(r);
    end
    r = '0;
    r.gnt  = NREQ'(1) << j;
    r.done = NREQ'(1) << j;
    r.busy = 1'b1;
    r.sh   = WIDTH'(d ? s + int'(len) : s - int'(len));
    exp_q.push_back(r);
    m_shadow = r.sh;
    m_ptr    = j;
  endtask

  // Check the current cycle at the falling edge, then drive inputs for the next rising edge.
  task automatic step(input bit rst, input bit clr, input logic [NREQ-1:0] rq,
                      input logic [NREQ-1:0] dr, input logic [NREQ*LEN_W-1:0] ln);
    rec_t e;
    rec_t o;
    @(negedge clk);
    if (prev_rst) begin
      e = '0;
      e.ctr = 1'b1;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = '0;
      e.sh = m_shadow;
    end
    o = {gnt, done, busy, up_down, down_up, ctr_reset, shadow};
    check_val("outputs", 32'(o), 32'(e));
    check_val("gnt_onehot0", 32'($countones(gnt) > 1), 32'd0);
    check_val("strobe_excl", 32'(up_down & down_up), 32'd0);
    for (int i = 0; i < int'(NREQ); i++) if (done[i]) done_log.push_back(i);
    reset   = rst;
    clr_req = clr;
    req     = rq;
    req_dir = dr;
    req_len = ln;
    if (rst) begin
      exp_q.delete();
      m_shadow = '0;
      m_ptr    = NREQ - 1;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      if (!e.busy) model_idle(clr, rq, dr, ln);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [NREQ-1:0]       r_rq;
    logic [NREQ-1:0]       r_dr;
    logic [NREQ*LEN_W-1:0] r_ln;
    reset   = 1'b1;
    clr_req = 1'b0;
    req     = '0;
    req_dir = '0;
    req_len = '0;

    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);

    // Up burst of 3 from requester 0.
    step(1'b0, 1'b0, 4'b0001, 4'b0001, 16'h0003);
    idle_cycles(5);
    check_val("shadow_after_up3", 32'(shadow), 32'd3);

    // Down burst of 5 from requester 2, wrapping through zero.
    step(1'b0, 1'b0, 4'b0100, 4'b0000, 16'h0500);
    idle_cycles(7);
    check_val("shadow_after_dn5", 32'(shadow), 32'd14);

    // All requesters, len 1 each, from a fresh pointer.
    step(1'b1, 1'b0, '0, '0, '0);
    done_log.delete();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'b1111, 4'b1111, 16'h1111);
    idle_cycles(3);
    check_val("rr_count", 32'(done_log.size() >= 5), 32'd1);
    if (done_log.size() >= 5) begin
      check_val("rr_order0", 32'(done_log[0]), 32'd0);
      check_val("rr_order1", 32'(done_log[1]), 32'd1);
      check_val("rr_order2", 32'(done_log[2]), 32'd2);
      check_val("rr_order3", 32'(done_log[3]), 32'd3);
      check_val("rr_order4", 32'(done_log[4]), 32'd0);
    end

    // Clear beats a simultaneous request; the request follows.
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 16'h0020);
    step(1'b0, 1'b0, 4'b0010, 4'b0010, 16'h0020);
    check_val("clr_strobe", 32'(ctr_reset), 32'd1);
    check_val("clr_shadow", 32'(shadow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0010, 4'b0010, 16'h0020);
    idle_cycles(3);
    check_val("shadow_after_clr_up2", 32'(shadow), 32'd2);

    // Zero-length burst: grant and done together, no strobes.
    step(1'b0, 1'b0, 4'b1000, 4'b1000, 16'h0000);
    step(1'b0, 1'b0, '0, '0, '0);
    check_val("len0_gnt_done", 32'({gnt, done}), 32'h88);
    idle_cycles(2);
    check_val("len0_shadow", 32'(shadow), 32'd2);

    // Reset during a len-6 burst aborts it.
    step(1'b0, 1'b0, 4'b0001, 4'b0001, 16'h0006);
    step(1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0);
    check_val("abort_shadow", 32'(shadow), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    idle_cycles(4);

    for (int c = 0; c < 4000; c++) begin
      r_rq = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
      r_dr = NREQ'($urandom);
      for (int i = 0; i < int'(NREQ); i++) r_ln[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 6));
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 24) == 0), r_rq, r_dr, r_ln);
    end
    idle_cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/counter_req_arbiter.md
Name: counter_req_arbiter

Overview:
- Shares one 4-bit up/down counter between NREQ requesters.
- Each requester asks for a burst of L unit steps in one direction. The block grants requesters round-robin and drives the counter's up-step, down-step and clear strobes.
- Keeps a shadow copy of the counter value that equals the counter output every cycle.
- Sits between requester logic and the up/down counter instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, counter/shadow width.
- LEN_W, 4, width of each burst-length field.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level
- req_dir  in  NREQ  per-requester direction; 1 = up, 0 = down
- req_len  in  NREQ*LEN_W  per-requester step count; requester i uses bits [i*LEN_W +: LEN_W]
- clr_req  in  1  request to clear the counter; beats any pending req
- gnt  out  NREQ  one-hot grant, registered
- done  out  NREQ  one-cycle pulse on the granted bit when its burst completes
- busy  out  1  high whenever state != IDLE
- up_down  out  1  counter up-step strobe, one step per high cycle
- down_up  out  1  counter down-step strobe, one step per high cycle
- ctr_reset  out  1  counter clear strobe
- shadow  out  WIDTH  mirror of the counter value

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; rr pointer = NREQ-1, so requester 0 has first priority.
  - gnt = 0, done = 0, busy = 0, up_down = 0, down_up = 0.
  - ctr_reset = 1 during the reset cycle(s); shadow = 0.
  - Reset mid-burst aborts the burst. No done pulse is issued.
- States: IDLE, CLR, RUN, DONE. All outputs are registered.
- IDLE:
  - If clr_req: go to CLR; ctr_reset = 1 for exactly one cycle; shadow <= 0.
  - Else if any req: select the first asserted req scanning from ptr+1 upward, with wrap. Latch idx, dir and len; set gnt[idx].
    - len != 0: go to RUN. The strobe for step 1 is high in the next cycle.
    - len == 0: go to DONE directly. No strobes are issued.
  - Else stay in IDLE.
  - req, req_dir, req_len and clr_req are sampled only in IDLE. Changes at other times are ignored; a latched burst always completes.
- Latency: req seen in IDLE in cycle t gives:
  - gnt high in cycles t+1 .. t+L+1;
  - strobes in cycles t+1 .. t+L (up_down if dir=1, else down_up; never both);
  - done[idx] and DONE state in cycle t+L+1.
- RUN: one strobe per cycle. The remaining count decrements each cycle. When the last step is issued, go to DONE.
- DONE:
  - done[idx] pulses; ptr <= idx; go to IDLE.
  - gnt and done drop the next cycle.
  - Earliest next grant is at t+L+3.
  - The requester must drop req in the cycle after done, or it re-enters arbitration at lowest priority.
- CLR: one cycle, then IDLE.
- shadow: +1 (up) or -1 (down) at the edge ending each strobe cycle. Arithmetic is modulo 2^WIDTH, so 15+1 = 0 and 0-1 = 15, matching counter wrap.
- clr_req and req both high in IDLE: the clear wins; the req is served after CLR.

Decomposition:
- Package counter_arb_pkg holds:
  - state enum typedef {IDLE, CLR, RUN, DONE};
  - defaults for WIDTH and LEN_W.
- Sub-module rr_arbiter (NREQ): combinational. Inputs req and ptr; outputs a one-hot grant and a valid flag.
- FSM, shadow and strobes stay in the top module.

Test Plan:
- Reset, then req[0]=1, dir=1, len=3 → gnt=0001 for 4 cycles; up_down high for 3 cycles; done[0] in the 4th cycle; shadow=3.
- Shadow=3, then req[2]=1, dir=0, len=5 → down_up high for 5 cycles; shadow walks 2,1,0,15,14 (wrap); done[2] pulses once.
- req=1111 held, each len=1 → grant order 0,1,2,3,0; one up_down per grant; never two gnt bits high.
- clr_req and req[1] high together in IDLE → ctr_reset for 1 cycle and shadow=0; then gnt[1] is served.
- req[3]=1, len=0 → gnt[3] and done[3] in the same single cycle; no strobes; shadow unchanged.
- reset asserted at step 2 of a len=6 burst → next cycle all outputs are at reset values; no done pulse; shadow=0.
